// File: rtl/marker_pkg.sv
// marker_pkg: shared pixel-class, run types and helpers for the marker row scanner
package marker_pkg;
  localparam int RW = 16;
  typedef enum logic [1:0] {CLS_GREY, CLS_BLACK, CLS_WHITE} pix_class_t;
  typedef logic [RW:0] wide_t;
  typedef struct packed {
    logic [RW-1:0] len;
    logic [RW-1:0] start_x;
    pix_class_t    colour;
  } run_t;
  function automatic wide_t abs_diff(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
  endfunction
endpackage

// File: rtl/marker_run_encoder.sv
// marker_run_encoder: classifies pixels and closes glitch-filtered colour runs
module marker_run_encoder
  import marker_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int COORD_W    = 11,
  parameter int MAX_RUN    = 100,
  parameter int GLITCH_LEN = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sol_in,
  input  logic             pixel_valid_in,
  input  logic [PIX_W-1:0] luma_in,
  input  logic [PIX_W-1:0] black_thr_in,
  input  logic [PIX_W-1:0] white_thr_in,
  output logic             close_valid_out,
  output run_t             run_out
);
  localparam int PW = $clog2(GLITCH_LEN + 1);
  localparam logic [COORD_W-1:0] LEN_SAT = COORD_W'(MAX_RUN + 1);
  pix_class_t cls_in, cls_b, cls_q, cls_d;
  logic [COORD_W-1:0] x_b, x_q, x_d, len_b, len_q, len_d, start_b, start_q, start_d;
  logic [PW-1:0] pend_b, pend_q, pend_d;
  logic close_d;
  run_t run_d;
  int len_sum;
  // start of line restarts from the cleared state so its pixel lands at x = 0
  always_comb begin
    cls_in = luma_in <= black_thr_in ? CLS_BLACK : luma_in >= white_thr_in ? CLS_WHITE : CLS_GREY;
    cls_b = sol_in ? CLS_GREY : cls_q;
    x_b = sol_in ? '0 : x_q;
    len_b = sol_in ? '0 : len_q;
    start_b = sol_in ? '0 : start_q;
    pend_b = sol_in ? '0 : pend_q;
    len_sum = int'(len_b) + int'(pend_b) + 1;
    x_d = x_b;
    cls_d = cls_b;
    len_d = len_b;
    start_d = start_b;
    pend_d = pend_b;
    close_d = 1'b0;
    run_d = '{len: RW'(len_b), start_x: RW'(start_b), colour: cls_b};
    if (pixel_valid_in) begin
      x_d = &x_b ? x_b : x_b + 1'b1;
      if (cls_in == cls_b) begin
        len_d = len_sum > MAX_RUN ? LEN_SAT : COORD_W'(len_sum);
        pend_d = '0;
      end else if (int'(pend_b) == GLITCH_LEN - 1) begin
        close_d = 1'b1;
        cls_d = cls_in;
        len_d = COORD_W'(GLITCH_LEN);
        start_d = x_b - COORD_W'(GLITCH_LEN - 1);
        pend_d = '0;
      end else begin
        pend_d = pend_b + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q <= '0;
      cls_q <= CLS_GREY;
      len_q <= '0;
      start_q <= '0;
      pend_q <= '0;
      close_valid_out <= 1'b0;
      run_out <= '0;
    end else begin
      x_q <= x_d;
      cls_q <= cls_d;
      len_q <= len_d;
      start_q <= start_d;
      pend_q <= pend_d;
      close_valid_out <= close_d;
      run_out <= run_d;
    end
  end
endmodule

// File: rtl/marker_row_scanner.sv
// marker_row_scanner: matches a sliding window of colour runs against a concentric-ring target
module marker_row_scanner
  import marker_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int COORD_W    = 11,
  parameter int SIDE_RUNS  = 5,
  parameter int MIN_RUN    = 3,
  parameter int MAX_RUN    = 100,
  parameter int GLITCH_LEN = 2,
  parameter int TOL_SHIFT  = 1,
  parameter int SCORE_W    = 15
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               sol_in,
  input  logic               pixel_valid_in,
  input  logic [PIX_W-1:0]   luma_in,
  input  logic [PIX_W-1:0]   black_thr_in,
  input  logic [PIX_W-1:0]   white_thr_in,
  output logic               hit_valid_out,
  output logic [COORD_W-1:0] coord_out,
  output logic [COORD_W-1:0] centre_width_out,
  output logic [SCORE_W-1:0] score_out,
  output logic [3:0]         hit_count_out,
  output logic [3:0]         run_depth_out
);
  localparam int N = 2 * SIDE_RUNS + 1;
  localparam int DW = $clog2(N + 1);
  localparam wide_t MIN_W = wide_t'(MIN_RUN);
  localparam wide_t MAX_W = wide_t'(MAX_RUN);
  logic close, shift, match, hit_q;
  run_t run, ctr;
  run_t win_q [N];
  run_t win_d [N];
  logic [DW-1:0] depth_q, depth_d;
  wide_t ref_len, tol, len_w, diff;
  logic [31:0] sum;
  logic [COORD_W-1:0] coord_d, coord_q, width_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [3:0] count_q;
  marker_run_encoder #(
    .PIX_W(PIX_W), .COORD_W(COORD_W), .MAX_RUN(MAX_RUN), .GLITCH_LEN(GLITCH_LEN)
  ) u_enc (
    .clk_in(clk_in), .rst_in(rst_in), .sol_in(sol_in), .pixel_valid_in(pixel_valid_in),
    .luma_in(luma_in), .black_thr_in(black_thr_in), .white_thr_in(white_thr_in),
    .close_valid_out(close), .run_out(run)
  );
  // win[0] is the newest run; grey or over-long runs break any candidate target
  always_comb begin
    shift = close && run.colour != CLS_GREY && run.len <= RW'(MAX_RUN);
    win_d = win_q;
    depth_d = close && !shift ? '0 : depth_q;
    if (shift) begin
      win_d[0] = run;
      for (int i = 1; i < N; i++) win_d[i] = win_q[i-1];
      depth_d = int'(depth_q) == N ? depth_q : depth_q + 1'b1;
    end
    ctr = win_d[SIDE_RUNS];
    ref_len = {1'b0, ctr.len} >> 1;
    tol = ref_len >> TOL_SHIFT;
    match = shift && int'(depth_d) == N && win_d[N-1].colour == CLS_BLACK && ctr.colour == CLS_WHITE;
    for (int i = 1; i < N; i++) if (win_d[i].colour == win_d[i-1].colour) match = 1'b0;
    sum = '0;
    len_w = '0;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      if (i != SIDE_RUNS) begin
        len_w = {1'b0, win_d[i].len};
        diff = abs_diff(win_d[i].len, ref_len[RW-1:0]);
        if (len_w < MIN_W || len_w > MAX_W || diff > tol) match = 1'b0;
        sum = sum + 32'(diff);
      end
    end
    score_d = sum > 32'(2**SCORE_W - 1) ? '1 : SCORE_W'(sum);
    coord_d = COORD_W'(ctr.start_x + (ctr.len >> 1));
  end
  always_ff @(posedge clk_in) win_q <= win_d;
  always_ff @(posedge clk_in) begin
    if (rst_in || sol_in) begin
      depth_q <= '0;
      hit_q <= 1'b0;
      coord_q <= '0;
      width_q <= '0;
      score_q <= '0;
      count_q <= '0;
    end else begin
      depth_q <= match ? '0 : depth_d;
      hit_q <= match;
      if (match) begin
        coord_q <= coord_d;
        width_q <= COORD_W'(ctr.len);
        score_q <= score_d;
        count_q <= &count_q ? count_q : count_q + 1'b1;
      end
    end
  end
  assign hit_valid_out = hit_q;
  assign coord_out = coord_q;
  assign centre_width_out = width_q;
  assign score_out = score_q;
  assign hit_count_out = count_q;
  assign run_depth_out = int'(depth_q) > 15 ? 4'd15 : 4'(depth_q);
endmodule

// File: tb/tb_marker_row_scanner.sv
// tb_marker_row_scanner: scoreboard bench driving synthetic marker rows
module tb_marker_row_scanner;
  localparam byte unsigned B = 8'd10, W = 8'd230, G = 8'd120;
  typedef struct {
    int trig;
    int coord;
    int width;
    int score;
    int count;
    int cyc;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1, sol_in = 1'b0, pixel_valid_in = 1'b0;
  logic [7:0] luma_in = '0, black_thr_in = 8'd40, white_thr_in = 8'd200;
  logic hit_valid_out;
  logic [10:0] coord_out, centre_width_out;
  logic [14:0] score_out;
  logic [3:0] hit_count_out, run_depth_out;
  int checks = 0, errors = 0, cyc = 0;
  byte unsigned row[$];
  exp_t want[$];
  exp_t sb[$];
  exp_t mon_e;
  int rings [10];

  marker_row_scanner dut (
    .clk_in(clk_in), .rst_in(rst_in), .sol_in(sol_in), .pixel_valid_in(pixel_valid_in),
    .luma_in(luma_in), .black_thr_in(black_thr_in), .white_thr_in(white_thr_in),
    .hit_valid_out(hit_valid_out), .coord_out(coord_out), .centre_width_out(centre_width_out),
    .score_out(score_out), .hit_count_out(hit_count_out), .run_depth_out(run_depth_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (hit_valid_out) begin
      if (sb.size() == 0) chk("unexpected_hit", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("hit_cycle", cyc, mon_e.cyc);
        chk("hit_coord", int'(coord_out), mon_e.coord);
        chk("hit_width", int'(centre_width_out), mon_e.width);
        chk("hit_score", int'(score_out), mon_e.score);
        chk("hit_count", int'(hit_count_out), mon_e.count);
      end
    end
  end

  task automatic seg(input byte unsigned v, input int n);
    repeat (n) row.push_back(v);
  endtask

  task automatic marker(input int rw [10]);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) seg(W, 16);
      seg(((i < 5 ? i : i - 5) % 2 == 0) ? B : W, rw[i]);
    end
  endtask

  task automatic std_row(input int rw [10]);
    row.delete();
    seg(W, 20);
    marker(rw);
    seg(W, 14);
  endtask

  task automatic expect_hit(input int trig, input int coord, input int width, input int score, input int count);
    exp_t e;
    e = '{trig: trig, coord: coord, width: width, score: score, count: count, cyc: 0};
    want.push_back(e);
  endtask

  task automatic send_row(input int n);
    exp_t e;
    for (int x = 0; x < n; x++) begin
      @(posedge clk_in);
      #1;
      sol_in = x == 0;
      pixel_valid_in = 1'b1;
      luma_in = row[x];
      if (want.size() > 0 && want[0].trig == x) begin
        e = want.pop_front();
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk_in);
    #1;
    sol_in = 1'b0;
    pixel_valid_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic end_row(input string tag, input int cnt);
    idle(6);
    chk({tag, "_count"}, int'(hit_count_out), cnt);
    chk({tag, "_pending"}, want.size() + sb.size(), 0);
    want.delete();
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk("rst_hit", int'(hit_valid_out), 0);
    chk("rst_coord", int'(coord_out), 0);
    chk("rst_width", int'(centre_width_out), 0);
    chk("rst_score", int'(score_out), 0);
    chk("rst_count", int'(hit_count_out), 0);
    chk("rst_depth", int'(run_depth_out), 0);

    rings = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
    std_row(rings);
    expect_hit(117, 68, 16, 0, 1);
    send_row(row.size());
    end_row("t1", 1);
    chk("t1_depth", int'(run_depth_out), 0);
    chk("t1_hold_coord", int'(coord_out), 68);

    std_row(rings);
    row[64] = G;
    expect_hit(117, 68, 16, 0, 1);
    send_row(row.size());
    end_row("t2", 1);

    rings[6] = 13;
    std_row(rings);
    send_row(row.size());
    end_row("t3", 0);
    chk("t3_depth", int'(run_depth_out), 11);

    rings = '{10, 6, 8, 8, 8, 8, 8, 8, 8, 8};
    std_row(rings);
    expect_hit(117, 68, 16, 4, 1);
    send_row(row.size());
    end_row("t4", 1);

    rings = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
    row.delete();
    seg(W, 10);
    seg(B, 150);
    seg(W, 20);
    marker(rings);
    seg(W, 20);
    marker(rings);
    seg(W, 14);
    expect_hit(277, 228, 16, 0, 1);
    expect_hit(393, 344, 16, 0, 2);
    send_row(row.size());
    end_row("t5", 2);

    std_row(rings);
    send_row(100);
    chk("t6_depth_mid", int'(run_depth_out), 9);
    chk("t6_count_mid", int'(hit_count_out), 0);
    expect_hit(117, 68, 16, 0, 1);
    send_row(row.size());
    end_row("t6", 1);

    send_row(118);
    expect_hit(117, 68, 16, 0, 1);
    send_row(row.size());
    end_row("t7", 1);

    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("rst2_coord", int'(coord_out), 0);
    chk("rst2_count", int'(hit_count_out), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
